feature_map_collector: RTL and testbench

- Output-side counterpart of the 3x3 window generator.
- Accepts one convolution result per (row, col, channel), channel varying fastest, which is the order the window generator emits windows.
- Stores a full CHANNEL x ROW x COL map, then re-serializes it channel-major (channel, row, col; col fastest). This is the order the window generator's pixel-input port ingests, so the next layer consumes the stream directly.
- Single buffer; fill and drain never overlap.

---
 rtl/cnn_pkg.sv | 25 ++
 rtl/fmc_buffer_ram.sv | 24 ++
 rtl/feature_map_collector.sv | 138 +++++++++++++
 tb/tb_feature_map_collector.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN map geometry, collector state enum and
// the map_index(ch,row,col) helper used by RTL and benches.
package cnn_pkg;

  localparam int BIT     = 32;
  localparam int CHANNEL = 2;
  localparam int ROW     = 4;
  localparam int COL     = 4;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } fmc_state_e;

  function automatic int map_index(
    input int ch,
    input int row,
    input int col,
    input int n_row = ROW,
    input int n_col = COL
  );
    return (ch * n_row + row) * n_col + col;
  endfunction

endpackage

// File: rtl/fmc_buffer_ram.sv
// fmc_buffer_ram: DEPTH x BIT register-file RAM, one sync write
// port (i_we/i_waddr/i_wdata) and one async read port (i_raddr/o_rdata).
module fmc_buffer_ram #(
  parameter  int BIT   = 32,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [BIT-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [BIT-1:0] o_rdata
);

  logic [BIT-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/feature_map_collector.sv
// feature_map_collector: buffers a CHANNEL x ROW x COL map arriving in
// (row,col,ch) order and re-serializes it in (ch,row,col) order.
// Ports: clk, rst_ (async low); in_valid/in_ready/in_data fill side;
// out_valid/out_ready/out_data/out_last drain side; frame_done, busy.
// Macro FEATURE_MAP_COLLECTOR_RELU_EN clamps negative words to 0 on write.
module feature_map_collector
  import cnn_pkg::*;
#(
  parameter int BIT     = cnn_pkg::BIT,
  parameter int CHANNEL = cnn_pkg::CHANNEL,
  parameter int ROW     = cnn_pkg::ROW,
  parameter int COL     = cnn_pkg::COL
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [BIT-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [BIT-1:0] out_data,
  output logic           out_last,
  output logic           frame_done,
  output logic           busy
);

  localparam int DEPTH = CHANNEL * ROW * COL;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH) + 1;

  fmc_state_e r_state;
  fmc_state_e w_next;

  logic [CW-1:0]  r_wc, r_wk, r_wr, r_rd;
  logic           w_acc, w_wlast;
  logic           w_take, w_end, w_load;
  logic [AW-1:0]  w_waddr;
  logic [BIT-1:0] w_wdata, w_rdata;

  assign w_acc   = in_valid && in_ready;
  assign w_wlast = (r_wc == CW'(CHANNEL-1))
                && (r_wk == CW'(COL-1))
                && (r_wr == CW'(ROW-1));
  assign w_take  = out_valid && out_ready;
  assign w_end   = w_take && out_last;
  // Refill the output register when empty or being consumed,
  // until every stored word has been issued.
  assign w_load  = (r_state == DRAIN)
                && (!out_valid || out_ready)
                && (r_rd != CW'(DEPTH));

  assign w_waddr = AW'(map_index(int'(r_wc), int'(r_wr),
                                 int'(r_wk), ROW, COL));

`ifdef FEATURE_MAP_COLLECTOR_RELU_EN
  assign w_wdata = in_data[BIT-1] ? '0 : in_data;
`else
  assign w_wdata = in_data;
`endif

  fmc_buffer_ram #(
    .BIT   (BIT),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_acc),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd[AW-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_state <= FILL;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      FILL:  if (w_acc && w_wlast) w_next = DRAIN;
      DRAIN: if (w_end)            w_next = FILL;
    endcase
  end

  always_comb begin
    in_ready = (r_state == FILL);
    busy     = (r_state == DRAIN);
  end

  // Write counters: channel fastest, then col, then row.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_wc <= '0;
      r_wk <= '0;
      r_wr <= '0;
    end else if (w_acc) begin
      if (w_wlast) begin
        r_wc <= '0;
        r_wk <= '0;
        r_wr <= '0;
      end else if (r_wc == CW'(CHANNEL-1)) begin
        r_wc <= '0;
        if (r_wk == CW'(COL-1)) begin
          r_wk <= '0;
          r_wr <= r_wr + 1'b1;
        end else begin
          r_wk <= r_wk + 1'b1;
        end
      end else begin
        r_wc <= r_wc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_rd       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_end;
      if (w_load) begin
        out_data  <= w_rdata;
        out_valid <= 1'b1;
        out_last  <= (r_rd == CW'(DEPTH-1));
        r_rd      <= r_rd + 1'b1;
      end else if (w_take) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (w_end) r_rd <= '0;
    end
  end

endmodule

// File: tb/tb_feature_map_collector.sv
// tb_feature_map_collector: randomized fill/drain scenarios checked
// against an array-based reorder model of the collector.
module tb_feature_map_collector;
  import cnn_pkg::*;

  localparam int N = CHANNEL * ROW * COL;

  logic           clk = 1'b0;
  logic           rst_ = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [BIT-1:0] in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [BIT-1:0] out_data;
  logic           out_last;
  logic           frame_done;
  logic           busy;

  feature_map_collector dut (
    .clk        (clk),
    .rst_       (rst_),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [BIT-1:0] fr [N];
  logic [BIT-1:0] exp_q[$];
  logic [BIT-1:0] got_q[$];
  bit             last_q[$];
  int n_fd, n_irbad, n_fdbad, first_v, n_unst, n_dead;

  function automatic logic [BIT-1:0] relu(input logic [BIT-1:0] v);
`ifdef FEATURE_MAP_COLLECTOR_RELU_EN
    return ($signed(v) < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Model: place each word in a 3-D map by its arrival coordinates,
  // then read the map back channel by channel.
  task automatic build_exp();
    logic [BIT-1:0] m [CHANNEL][ROW][COL];
    int i = 0;
    for (int r = 0; r < ROW; r++)
      for (int k = 0; k < COL; k++)
        for (int c = 0; c < CHANNEL; c++) begin
          m[c][r][k] = relu(fr[i]);
          i++;
        end
    exp_q.delete();
    for (int c = 0; c < CHANNEL; c++)
      for (int r = 0; r < ROW; r++)
        for (int k = 0; k < COL; k++)
          exp_q.push_back(m[c][r][k]);
  endtask

  task automatic rand_frame();
    for (int i = 0; i < N; i++) begin
      fr[i] = $urandom;
      if (fr[i] == 32'hDEAD) fr[i] = 32'h1DEAD;
    end
  endtask

  task automatic feed(input int n, input int gap);
    int  i = 0;
    int  cyc = 0;
    bit  ir;
    while (i < n && cyc < 5000) begin
      in_valid = ($urandom_range(99) >= gap);
      in_data  = in_valid ? fr[i] : $urandom;
      ir = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (in_valid && ir) i++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (i != n) begin
      n_fail++;
      $display("FAIL feed_timeout accepted=%0d required=%0d", i, n);
    end
  endtask

  task automatic drain(input int mode, input int stall_word,
                       input bit dead);
    int cyc = 0;
    int stall = 0;
    int post = -1;
    logic [BIT-1:0] held = '0;
    got_q.delete();
    last_q.delete();
    n_fd = 0; n_irbad = 0; n_fdbad = 0;
    first_v = -1; n_unst = 0; n_dead = 0;
    in_valid = dead;
    in_data  = 32'hDEAD;
    while (cyc < 3000 && post != 0) begin
      if (out_valid && first_v < 0) first_v = cyc;
      if (frame_done) begin
        n_fd++;
        if (!in_ready || busy) n_fdbad++;
        if (post < 0) post = 4;
        in_valid = 1'b0;
      end else if (post < 0 && (in_ready || !busy)) begin
        n_irbad++;
      end
      if (mode == 0) begin
        out_ready = 1'b1;
      end else if (out_valid && got_q.size() == stall_word
                   && stall < 10) begin
        if (stall == 0) held = out_data;
        else if (out_data !== held) n_unst++;
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'($urandom_range(1));
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
        if (out_data == 32'hDEAD) n_dead++;
      end
      @(posedge clk); #1;
      cyc++;
      if (post > 0) post--;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_tests++;
    if (post != 0) begin
      n_fail++;
      $display("FAIL drain_timeout words=%0d required=%0d",
               got_q.size(), N);
    end
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    #12;
    n_tests++;
    if ({in_ready, out_valid, out_last, frame_done, busy} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags got=%b required=10000",
               {in_ready, out_valid, out_last, frame_done, busy});
    end
    n_tests++;
    if (out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data got=%h required=0", out_data);
    end
    rst_ = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got=%b required=1", in_ready);
    end
  endtask

  task automatic test_order();
    for (int r = 0; r < ROW; r++)
      for (int k = 0; k < COL; k++)
        for (int c = 0; c < CHANNEL; c++)
          fr[(r*COL + k)*CHANNEL + c] = BIT'(100*c + 10*r + k);
    build_exp();
    feed(N, 0);
    drain(0, 0, 1'b0);
    n_tests++;
    if (got_q.size() != N) begin
      n_fail++;
      $display("FAIL order_count got=%0d required=%0d", got_q.size(), N);
    end
    for (int j = 0; j < N && j < got_q.size(); j++) begin
      n_tests++;
      if (got_q[j] !== exp_q[j] || last_q[j] !== (j == N-1)) begin
        n_fail++;
        $display("FAIL order_word[%0d] got=%0d/%b required=%0d/%b",
                 j, got_q[j], last_q[j], exp_q[j], j == N-1);
      end
    end
    n_tests++;
    if (got_q.size() == N && got_q[N-1] !== 133) begin
      n_fail++;
      $display("FAIL order_final got=%0d required=133", got_q[N-1]);
    end
    n_tests++;
    if (first_v != 1) begin
      n_fail++;
      $display("FAIL order_latency got=%0d required=1", first_v);
    end
    n_tests++;
    if (n_fd != 1 || n_fdbad != 0 || n_irbad != 0) begin
      n_fail++;
      $display("FAIL order_flags fd=%0d fdbad=%0d irbad=%0d required=1/0/0",
               n_fd, n_fdbad, n_irbad);
    end
  endtask

  task automatic test_gaps();
    rand_frame();
    build_exp();
    feed(N, 50);
    drain(0, 0, 1'b0);
    n_tests++;
    if (got_q.size() != N) begin
      n_fail++;
      $display("FAIL gaps_count got=%0d required=%0d", got_q.size(), N);
    end
    for (int j = 0; j < N && j < got_q.size(); j++) begin
      n_tests++;
      if (got_q[j] !== exp_q[j]) begin
        n_fail++;
        $display("FAIL gaps_word[%0d] got=%h required=%h",
                 j, got_q[j], exp_q[j]);
      end
    end
    n_tests++;
    if (n_fd != 1 || n_irbad != 0) begin
      n_fail++;
      $display("FAIL gaps_flags fd=%0d irbad=%0d required=1/0",
               n_fd, n_irbad);
    end
  endtask

  task automatic test_backpressure();
    rand_frame();
    build_exp();
    feed(N, 20);
    drain(1, 5, 1'b0);
    n_tests++;
    if (got_q.size() != N) begin
      n_fail++;
      $display("FAIL bp_count got=%0d required=%0d", got_q.size(), N);
    end
    for (int j = 0; j < N && j < got_q.size(); j++) begin
      n_tests++;
      if (got_q[j] !== exp_q[j] || last_q[j] !== (j == N-1)) begin
        n_fail++;
        $display("FAIL bp_word[%0d] got=%h/%b required=%h/%b",
                 j, got_q[j], last_q[j], exp_q[j], j == N-1);
      end
    end
    n_tests++;
    if (n_unst != 0) begin
      n_fail++;
      $display("FAIL bp_stall_stable changes=%0d required=0", n_unst);
    end
    n_tests++;
    if (n_fd != 1 || n_irbad != 0 || n_fdbad != 0) begin
      n_fail++;
      $display("FAIL bp_flags fd=%0d irbad=%0d fdbad=%0d required=1/0/0",
               n_fd, n_irbad, n_fdbad);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      rand_frame();
      build_exp();
      feed(N, 10);
      drain(1, 30, 1'b1);
      n_tests++;
      if (got_q.size() != N || n_dead != 0) begin
        n_fail++;
        $display("FAIL b2b_frame%0d count=%0d dead=%0d required=%0d/0",
                 f, got_q.size(), n_dead, N);
      end
      for (int j = 0; j < N && j < got_q.size(); j++) begin
        n_tests++;
        if (got_q[j] !== exp_q[j]) begin
          n_fail++;
          $display("FAIL b2b_frame%0d_word[%0d] got=%h required=%h",
                   f, j, got_q[j], exp_q[j]);
        end
      end
    end
  endtask

  task automatic test_reset_midfill();
    rand_frame();
    feed(17, 30);
    rst_ = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, out_valid, out_last, frame_done, busy} !== 5'b10000
        || out_data !== '0) begin
      n_fail++;
      $display("FAIL rstmid_flags got=%b/%h required=10000/0",
               {in_ready, out_valid, out_last, frame_done, busy}, out_data);
    end
    #2;
    rst_ = 1'b1;
    @(posedge clk); #1;
    rand_frame();
    build_exp();
    feed(N, 0);
    drain(0, 0, 1'b0);
    n_tests++;
    if (got_q.size() != N || n_fd != 1) begin
      n_fail++;
      $display("FAIL rstmid_count got=%0d/%0d required=%0d/1",
               got_q.size(), n_fd, N);
    end
    for (int j = 0; j < N && j < got_q.size(); j++) begin
      n_tests++;
      if (got_q[j] !== exp_q[j]) begin
        n_fail++;
        $display("FAIL rstmid_word[%0d] got=%h required=%h",
                 j, got_q[j], exp_q[j]);
      end
    end
  endtask

  task automatic test_relu();
    rand_frame();
    fr[0] = 32'hFFFF_FFFF;
    fr[1] = 32'h8000_0000;
    fr[2] = 32'h0000_0005;
    build_exp();
    feed(N, 0);
    drain(0, 0, 1'b0);
    n_tests++;
    if (got_q.size() != N) begin
      n_fail++;
      $display("FAIL relu_count got=%0d required=%0d", got_q.size(), N);
    end
    for (int j = 0; j < N && j < got_q.size(); j++) begin
      n_tests++;
      if (got_q[j] !== exp_q[j]) begin
        n_fail++;
        $display("FAIL relu_word[%0d] got=%h required=%h",
                 j, got_q[j], exp_q[j]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_gaps();
    test_backpressure();
    test_back_to_back();
    test_reset_midfill();
    test_relu();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
